// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter that turns each 32-bit word request into four
// big-endian single-byte beats on a byte-wide data memory, then returns one
// response pulse to the requesting port.
module data_mem_arbiter #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned MA_W      = $clog2(MEM_BYTES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_write,
    input  logic [63:0]     req0_addr,
    input  logic [31:0]     req0_wdata,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_write,
    input  logic [63:0]     req1_addr,
    input  logic [31:0]     req1_wdata,
    output logic            rsp0_valid,
    output logic [31:0]     rsp0_rdata,
    output logic            rsp0_err,
    output logic            rsp1_valid,
    output logic [31:0]     rsp1_rdata,
    output logic            rsp1_err,
    output logic [MA_W-1:0] mem_addr,
    output logic            mem_re,
    output logic            mem_we,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StXfer, StDrain, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic              port_q, port_d;
    logic              write_q, write_d;
    logic [MA_W-1:0]   addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rr_q, rr_d;          // 0: port 0 wins a tie, 1: port 1 wins
    logic [31:0]       rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;
    logic              rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;

    logic              accept, acc_port, acc_err;
    logic [63:0]       acc_addr;
    logic              rsp_load, rsp_port, rsp_err;
    logic [31:0]       rsp_word;

    // Arbitration: ready only in IDLE and never while reset is asserted.
    always_comb begin
        req0_ready = (state_q == StIdle) && !rst && req0_valid && (!req1_valid || !rr_q);
        req1_ready = (state_q == StIdle) && !rst && req1_valid && (!req0_valid || rr_q);
        accept     = req0_ready || req1_ready;
        acc_port   = req1_ready;
        acc_addr   = acc_port ? req1_addr : req0_addr;
        // addr+3 >= MEM_BYTES without 64-bit wrap
        acc_err    = acc_addr > 64'(MEM_BYTES - 4);
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = acc_err ? StResp : StXfer;
            StXfer:  if (beat_q == 2'd3) state_d = write_q ? StResp : StDrain;
            StDrain: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: request latch, beat counter, load assembly and held responses.
    always_comb begin
        beat_d       = beat_q;
        port_d       = port_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rr_d         = rr_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_rdata_d = rsp1_rdata_q;
        rsp1_err_d   = rsp1_err_q;
        rsp_load     = 1'b0;
        rsp_port     = port_q;
        rsp_err      = 1'b0;
        rsp_word     = 32'h0;

        if (state_q == StIdle && accept) begin
            beat_d  = 2'd0;
            port_d  = acc_port;
            write_d = acc_port ? req1_write : req0_write;
            addr_d  = acc_addr[MA_W-1:0];
            wdata_d = acc_port ? req1_wdata : req0_wdata;
            rr_d    = !acc_port;
            if (acc_err) begin
                rsp_load = 1'b1;
                rsp_port = acc_port;
                rsp_err  = 1'b1;
            end
        end
        if (state_q == StXfer) begin
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3 && write_q) rsp_load = 1'b1;
        end
        // Byte from beat k arrives one cycle later; the last one lands in DRAIN.
        if (!write_q && ((state_q == StXfer && beat_q != 2'd0) || state_q == StDrain)) begin
            rdata_d = {rdata_q[23:0], mem_rdata};
        end
        if (state_q == StDrain) begin
            rsp_load = 1'b1;
            rsp_word = {rdata_q[23:0], mem_rdata};
        end
        if (rsp_load) begin
            if (rsp_port) begin
                rsp1_rdata_d = rsp_word;
                rsp1_err_d   = rsp_err;
            end else begin
                rsp0_rdata_d = rsp_word;
                rsp0_err_d   = rsp_err;
            end
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy       = state_q != StIdle;
        mem_re     = (state_q == StXfer) && !write_q;
        mem_we     = (state_q == StXfer) && write_q;
        mem_addr   = (state_q == StXfer) ? addr_q + MA_W'(beat_q) : '0;
        mem_wdata  = 8'h00;
        if (mem_we) begin
            unique case (beat_q)
                2'd0: mem_wdata = wdata_q[31:24];
                2'd1: mem_wdata = wdata_q[23:16];
                2'd2: mem_wdata = wdata_q[15:8];
                2'd3: mem_wdata = wdata_q[7:0];
                default: mem_wdata = 8'h00;
            endcase
        end
        rsp0_valid = (state_q == StResp) && !port_q;
        rsp1_valid = (state_q == StResp) && port_q;
        rsp0_rdata = rsp0_rdata_q;
        rsp0_err   = rsp0_err_q;
        rsp1_rdata = rsp1_rdata_q;
        rsp1_err   = rsp1_err_q;
    end

    // State register with synchronous reset; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            beat_q       <= 2'd0;
            port_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            rdata_q      <= 32'h0;
            rr_q         <= 1'b0;
            rsp0_rdata_q <= 32'h0;
            rsp0_err_q   <= 1'b0;
            rsp1_rdata_q <= 32'h0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            port_q       <= port_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rr_q         <= rr_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: byte memory device, cycle-level transaction
// model compared on every negedge, plus directed requests with literal checks.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, w0, v1, w1;
    logic [63:0] a0, a1;
    logic [31:0] d0, d1;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [9:0]  mem_addr;
    logic        mem_re, mem_we, busy;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem [1024] = '{default: 8'h00};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0),
        .req0_ready (req0_ready),
        .req0_write (w0),
        .req0_addr  (a0),
        .req0_wdata (d0),
        .req1_valid (v1),
        .req1_ready (req1_ready),
        .req1_write (w1),
        .req1_addr  (a1),
        .req1_wdata (d1),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    // Byte-wide synchronous memory device.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: an accepted word occupies cycles T+1..T+end, with
    // end = 1 (range error), 5 (store) or 6 (load); beats sit in T+1..T+4.
    initial begin : model
        logic [7:0]  ref_mem [1024];
        bit          m_known, m_active, m_port, m_write, m_err, m_rr;
        logic [63:0] m_addr;
        logic [31:0] m_wdata;
        int          m_t, m_end, cyc, d, k;
        logic [31:0] h_rdata [2];
        logic        h_err [2];
        bit          in_txn, g0, g1, e_re, e_we, e_rv0, e_rv1;
        logic [9:0]  e_addr, ra;
        logic [7:0]  e_wd;
        logic [90:0] exp_v, act_v;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        m_known = 0; m_active = 0; m_rr = 0; cyc = 0; m_t = 0; m_end = 0;
        h_rdata[0] = 0; h_rdata[1] = 0; h_err[0] = 0; h_err[1] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            d = cyc - m_t;
            if (m_active && d > m_end) m_active = 0;
            in_txn = m_active && d >= 1;
            {e_re, e_we, e_rv0, e_rv1, g0, g1} = '0;
            e_addr = '0;
            e_wd   = '0;
            if (in_txn && !m_err && d <= 4) begin
                k      = d - 1;
                e_addr = m_addr[9:0] + 10'(k);
                e_we   = m_write;
                e_re   = !m_write;
                if (m_write) e_wd = m_wdata[31 - 8 * k -: 8];
            end
            if (in_txn && d == m_end) begin
                ra = m_addr[9:0];
                h_rdata[m_port] = (m_err || m_write) ? 32'h0 :
                    {ref_mem[ra], ref_mem[ra + 10'd1], ref_mem[ra + 10'd2], ref_mem[ra + 10'd3]};
                h_err[m_port] = m_err;
                e_rv0 = !m_port;
                e_rv1 = m_port;
            end
            if (!in_txn && !rst) begin
                g0 = v0 && (!v1 || !m_rr);
                g1 = v1 && (!v0 || m_rr);
            end
            if (m_known) begin
                exp_v = {g0, g1, e_rv0, h_rdata[0], h_err[0], e_rv1, h_rdata[1], h_err[1],
                         e_addr, e_re, e_we, e_wd, in_txn};
                act_v = {req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp0_err,
                         rsp1_valid, rsp1_rdata, rsp1_err, mem_addr, mem_re, mem_we,
                         mem_wdata, busy};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act_v, exp_v);
                end
            end
            if (e_we) ref_mem[e_addr] = e_wd;
            if (rst) begin
                m_active = 0; m_rr = 0; m_known = 1;
                h_rdata[0] = 0; h_rdata[1] = 0; h_err[0] = 0; h_err[1] = 0;
            end else if (g0 || g1) begin
                m_active = 1;
                m_t      = cyc;
                m_port   = g1;
                m_write  = g1 ? w1 : w0;
                m_addr   = g1 ? a1 : a0;
                m_wdata  = g1 ? d1 : d0;
                m_err    = m_addr > 64'd1020;
                m_end    = m_err ? 1 : (m_write ? 5 : 6);
                m_rr     = g0;
            end
        end
    end

    // One word request; lat counts cycles from accept to the response pulse.
    task automatic do_req(input bit p, input bit wr, input logic [63:0] ad, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        bit got = 0;
        lat = -1; rd = '0; er = 1'b0;
        @(posedge clk); #1;
        if (!p) begin v0 = 1; w0 = wr; a0 = ad; d0 = wd; end
        else    begin v1 = 1; w1 = wr; a1 = ad; d1 = wd; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = p ? req1_ready : req0_ready;
        end
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        if (!got) begin
            chk("accept timeout", 0, 1);
            return;
        end
        lat = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (p ? rsp1_valid : rsp0_valid) begin
                got = 1;
                rd  = p ? rsp1_rdata : rsp0_rdata;
                er  = p ? rsp1_err : rsp0_err;
            end
        end
        if (!got) chk("response timeout", 0, 1);
    endtask

    initial begin : stim
        int          lat, n0, n1, got, nr;
        logic [31:0] rd;
        logic        er;
        logic [3:0]  ord;
        bit          acc0, acc1;

        rst = 1; v0 = 1; w0 = 0; a0 = 64'd0; d0 = 0; v1 = 1; w1 = 0; a1 = 64'd4; d1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready/busy", {req0_ready, req1_ready, busy, mem_we, mem_re}, 5'b0);
        rst = 0;
        @(negedge clk);
        chk("first grant after reset", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        repeat (8) @(posedge clk);

        do_req(0, 1, 64'd8, 32'hFFFF_FF38, lat, rd, er);
        chk("store8 latency", lat, 5);
        chk("store8 rsp", {er, rd}, 33'h0);
        chk("store8 bytes", {mem[8], mem[9], mem[10], mem[11]}, 32'hFFFF_FF38);
        do_req(0, 0, 64'd8, 32'h0, lat, rd, er);
        chk("load8 latency", lat, 6);
        chk("load8 rdata", {er, rd}, {1'b0, 32'hFFFF_FF38});

        do_req(1, 0, 64'd1021, 32'h0, lat, rd, er);
        chk("range1021 latency", lat, 1);
        chk("range1021 rsp", {er, rd}, {1'b1, 32'h0});
        do_req(0, 1, 64'd1020, 32'hDEAD_BEEF, lat, rd, er);
        chk("store1020 latency", lat, 5);
        do_req(1, 0, 64'd1020, 32'h0, lat, rd, er);
        chk("load1020 rsp", {er, rd}, {1'b0, 32'hDEAD_BEEF});
        do_req(0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0, lat, rd, er);
        chk("range wrap rsp", {er, rd, lat[3:0]}, {1'b1, 32'h0, 4'd1});

        do_req(0, 1, 64'd5, 32'h1122_3344, lat, rd, er);
        chk("misaligned bytes", {mem[5], mem[6], mem[7], mem[8]}, 32'h1122_3344);
        do_req(1, 0, 64'd5, 32'h0, lat, rd, er);
        chk("misaligned load", {er, rd}, {1'b0, 32'h1122_3344});

        // Contention: pointer now favours port 0 (last grant went to port 1).
        @(posedge clk); #1;
        v0 = 1; w0 = 1; a0 = 64'd100; d0 = 32'hA0A1_A2A3;
        v1 = 1; w1 = 1; a1 = 64'd200; d1 = 32'hB0B1_B2B3;
        n0 = 0; n1 = 0; got = 0; ord = '0;
        for (int i = 0; i < 100 && got < 4; i++) begin
            @(negedge clk);
            acc0 = req0_ready;
            acc1 = req1_ready;
            if (acc0 || acc1) begin
                ord[got] = acc1;
                got++;
            end
            @(posedge clk); #1;
            if (acc0) begin
                n0++;
                if (n0 == 2) v0 = 0;
                else begin a0 = 64'd104; d0 = 32'hC0C1_C2C3; end
            end
            if (acc1) begin
                n1++;
                if (n1 == 2) v1 = 0;
                else begin a1 = 64'd204; d1 = 32'hD0D1_D2D3; end
            end
        end
        v0 = 0; v1 = 0;
        chk("contention grant count", got, 4);
        chk("contention order 0,1,0,1", ord, 4'b1010);
        repeat (8) @(posedge clk);
        chk("contention last store", {mem[204], mem[205], mem[206], mem[207]}, 32'hD0D1_D2D3);

        // Reset lands after beat 1 of a store to 16: bytes 16..17 only.
        @(posedge clk); #1;
        v0 = 1; w0 = 1; a0 = 64'd16; d0 = 32'hA1B2_C3D4;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            got = int'(req0_ready);
        end
        chk("abort accept", got, 1);
        @(posedge clk); #1;
        v0 = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        nr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nr += int'(rsp0_valid | rsp1_valid);
        end
        chk("abort no response", nr, 0);
        chk("abort idle", busy, 0);
        chk("abort bytes", {mem[16], mem[17], mem[18], mem[19]}, 32'hA1B2_0000);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
